mux_select_arbiter: RTL and testbench
=====================================

# mux_select_arbiter

Round-robin arbiter sharing one dual 4:1 multiplexer (74153-style: 2-bit select, per-section active-low enable) among four requesters. Each requester raises a request; the arbiter drives the mux select and enables so that exactly one requester's inputs reach the shared 2-bit output. Between grants it inserts a one-cycle dead gap with both sections disabled. Sits between the requesting units and the shared mux on the data bus.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles before pre-emption when another requester is waiting. 0 = unlimited; legal range 0..255.
- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high; sampled on the rising edge of `clock`.
- `req` input 4: request from requester i = `req[i]`; level-sensitive, held high for the whole transfer.
- `grant` output 4: one-hot grant to requester i, or 0; registered.
- `sel` output 2: mux select = index of granted requester; registered.
- `enable_n` output 2: mux section enables, active-low; 2'b00 while granted, 2'b11 otherwise; registered.
- `busy` output 1: high while any grant is active; registered.

## Operation
- States: IDLE, GRANT, GAP. Internal: `owner` (2 bits), `last` (2 bits, round-robin pointer), `hold` (8-bit cycle counter).
- Reset: state IDLE, `grant`=4'b0000, `sel`=2'd0, `enable_n`=2'b11, `busy`=0, `last`=2'd3 (requester 0 highest priority first), `hold`=0. Reset overrides everything, including mid-grant; `grant` drops on the same edge.
- Pick rule: first i with `req[i]`=1, scanning `last`+1, `last`+2, `last`+3, `last` (mod 4).
- IDLE: if `req`≠0, pick winner w → GRANT; `owner`=`last`=w, `grant`=1<<w, `sel`=w, `enable_n`=2'b00, `busy`=1, `hold`=1. Else stay.
- GRANT, each edge:
  - `req[owner]`=0 → GAP (release).
  - Else if `MAX_HOLD`≠0, `hold`≥`MAX_HOLD`, and any other `req` bit set → GAP (pre-emption).
  - Else stay; `hold` increments, saturating at 255.
- Entering GAP: `grant`=0, `enable_n`=2'b11, `busy`=0; `sel` holds its old value.
- GAP (exactly one cycle): if `req`≠0, pick per rule (pointer = old owner, so old owner is lowest priority) → GRANT as from IDLE; else → IDLE.
- Pre-empted requester keeping `req` high is re-arbitrated normally; it is served again only after every other pending requester, unless it is the only one requesting.
- `sel` always equals `owner` while `grant`≠0; `grant` is never multi-hot.
- Requests rising or falling for non-owners during GRANT do not change outputs.

## Timing
- All outputs registered; no combinational path from `req` to any output.
- Grant latency from IDLE: `req` high before edge k → `grant`/`sel`/`enable_n` valid after edge k (1 cycle).
- Release: owner `req` low before edge k → `grant`=0, `enable_n`=2'b11 after edge k; next grant, if pending, after edge k+1. Dead gap is always exactly 1 cycle.
- Pre-emption: owner holds the grant for exactly `MAX_HOLD` cycles when contended, then one GAP cycle.
- Back-to-back same requester (drops `req` for one cycle, re-raises, no others): grant, GAP, IDLE or GRANT according to `req` at the GAP edge.
- Reset mid-GRANT or mid-GAP: IDLE with reset values after the edge; arbitration restarts from requester 0.

## Test plan
- Reset then `req`=4'b0100 → one edge later `grant`=4'b0100, `sel`=2, `enable_n`=2'b00, `busy`=1; after `req`=0, `grant`=0 and `enable_n`=2'b11 the next edge, then IDLE.
- `req`=4'b1111 held, `MAX_HOLD`=8 → grants 0,1,2,3,0 in order; each grant exactly 8 cycles followed by one cycle with `enable_n`=2'b11.
- `req`=4'b0010 alone held 300 cycles, `MAX_HOLD`=8 → `grant`=4'b0010 continuous, no gap, `hold` saturates without wrap.
- Owner 1 releases while `req[1]` and `req[3]` are both pending (requester 1 re-raised in the gap) → next grant is 3, not 1.
- `MAX_HOLD`=0, `req`=4'b0011 → requester 0 keeps grant until it drops `req[0]`, then GAP, then requester 1.
- `reset` asserted during the 3rd cycle of a grant → `grant`=0, `enable_n`=2'b11, `sel`=0 after that edge; with `req`=4'b1010 after reset, first grant goes to requester 1.

Source files
------------

// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter
//
// Round-robin arbiter that shares one dual 4:1 multiplexer (74153-style:
// 2-bit select, per-section active-low enable) among four requesters.
// Exactly one requester's inputs are steered to the shared output at a time.
// Every hand-over passes through a one-cycle dead gap with both mux sections
// disabled, so two requesters never drive the shared bus in the same cycle.
//
// Parameters
//   MAX_HOLD  maximum consecutive grant cycles before pre-emption when another
//             requester is waiting; 0 disables pre-emption (legal 0..255)
//
// Ports
//   clock     sole clock, rising edge
//   reset     synchronous, active-high
//   req       [3:0] level-sensitive requests, req[i] belongs to requester i
//   grant     [3:0] one-hot grant (or zero), registered
//   sel       [1:0] mux select = index of granted requester, registered
//   enable_n  [1:0] mux section enables, active-low, registered
//   busy      high while a grant is active, registered

module mux_select_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] sel,
    output logic [1:0] enable_n,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIMIT   = 8'(MAX_HOLD);
    localparam logic       HOLD_ENABLED = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_MAX     = 8'hFF;

    state_t     state;
    state_t     state_next;
    logic [1:0] owner;
    logic [1:0] owner_next;
    logic [1:0] last;
    logic [1:0] last_next;
    logic [7:0] hold;
    logic [7:0] hold_next;

    logic [3:0] grant_next;
    logic [1:0] sel_next;
    logic [1:0] enable_n_next;
    logic       busy_next;

    logic [2:0] winner;
    logic       other_waiting;
    logic       hold_expired;
    logic       owner_released;

    // Round-robin pick: scan ptr+1, ptr+2, ptr+3, ptr (mod 4) and return
    // {found, index} of the first requester found. Starting just after the
    // pointer makes the previous owner the lowest priority.
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [2:0] result;
        logic [1:0] idx;
        result = 3'b000;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (r[idx] && !result[2]) begin
                result = {1'b1, idx};
            end
        end
        return result;
    endfunction

    assign winner         = pick(req, last);
    assign other_waiting  = |(req & ~(4'b0001 << owner));
    assign owner_released = !req[owner];

    // hold + 1 > limit is the same test as hold >= limit, written in nine
    // bits so that a limit of zero does not collapse into a constant compare.
    assign hold_expired = HOLD_ENABLED &&
                          (({1'b0, hold} + 9'd1) > {1'b0, HOLD_LIMIT});

    // Next-state and next-output logic. Outputs are computed here and then
    // registered, so nothing on req reaches an output combinationally.
    always_comb begin
        state_next    = state;
        owner_next    = owner;
        last_next     = last;
        hold_next     = hold;
        grant_next    = grant;
        sel_next      = sel;
        enable_n_next = enable_n;
        busy_next     = busy;

        case (state)
            IDLE, GAP: begin
                if (winner[2]) begin
                    state_next    = GRANT;
                    owner_next    = winner[1:0];
                    last_next     = winner[1:0];
                    grant_next    = 4'b0001 << winner[1:0];
                    sel_next      = winner[1:0];
                    enable_n_next = 2'b00;
                    busy_next     = 1'b1;
                    hold_next     = 8'd1;
                end else begin
                    state_next    = IDLE;
                    grant_next    = 4'b0000;
                    enable_n_next = 2'b11;
                    busy_next     = 1'b0;
                end
            end

            GRANT: begin
                if (owner_released || (hold_expired && other_waiting)) begin
                    // sel keeps its value through the gap; only the enables
                    // isolate the bus.
                    state_next    = GAP;
                    grant_next    = 4'b0000;
                    enable_n_next = 2'b11;
                    busy_next     = 1'b0;
                end else if (hold != HOLD_MAX) begin
                    hold_next = hold + 8'd1;
                end
            end

            default: begin
                state_next    = IDLE;
                grant_next    = 4'b0000;
                enable_n_next = 2'b11;
                busy_next     = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset pulls everything back to idle and
    // points last at requester 3, so requester 0 is first in line afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 2'd0;
            last     <= 2'd3;
            hold     <= 8'd0;
            grant    <= 4'b0000;
            sel      <= 2'd0;
            enable_n <= 2'b11;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            owner    <= owner_next;
            last     <= last_next;
            hold     <= hold_next;
            grant    <= grant_next;
            sel      <= sel_next;
            enable_n <= enable_n_next;
            busy     <= busy_next;
        end
    end

endmodule

// File: tb/tb_mux_select_arbiter.sv
// tb_mux_select_arbiter
//
// Two arbiter instances share clock and reset: dut_a uses the default
// MAX_HOLD (8), dut_b uses MAX_HOLD = 0. The driver issues one input vector
// per cycle and queues the hand-computed outputs expected after the next
// rising edge; the monitor pops one entry per rising edge and compares.
// Output word layout: {grant[3:0], sel[1:0], enable_n[1:0], busy}.

module tb_mux_select_arbiter;

    typedef struct {
        logic [8:0] a;
        logic [8:0] b;
        string      name;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic [3:0] grant_a;
    logic [1:0] sel_a;
    logic [1:0] enable_n_a;
    logic       busy_a;
    logic [3:0] grant_b;
    logic [1:0] sel_b;
    logic [1:0] enable_n_b;
    logic       busy_b;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    mux_select_arbiter dut_a (
        .clock    (clock),
        .reset    (reset),
        .req      (req_a),
        .grant    (grant_a),
        .sel      (sel_a),
        .enable_n (enable_n_a),
        .busy     (busy_a)
    );

    mux_select_arbiter #(.MAX_HOLD(0)) dut_b (
        .clock    (clock),
        .reset    (reset),
        .req      (req_b),
        .grant    (grant_b),
        .sel      (sel_b),
        .enable_n (enable_n_b),
        .busy     (busy_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Expected word while requester w is granted.
    function automatic logic [8:0] g(input int w);
        logic [3:0] onehot;
        onehot = 4'b0001 << w;
        return {onehot, 2'(w), 2'b00, 1'b1};
    endfunction

    // Expected word while nothing is granted and sel rests at s.
    function automatic logic [8:0] off(input int s);
        return {4'b0000, 2'(s), 2'b11, 1'b0};
    endfunction

    task automatic apply_stimulus(input logic rst, input logic [3:0] ra,
                                  input logic [3:0] rb, input logic [8:0] ea,
                                  input logic [8:0] eb, input string nm);
        exp_t item;
        @(negedge clock);
        reset = rst;
        req_a = ra;
        req_b = rb;
        item.a    = ea;
        item.b    = eb;
        item.name = nm;
        sb.push_back(item);
    endtask

    task automatic check_output(input string nm, input string which,
                                input logic [8:0] got, input logic [8:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s %s: got {grant,sel,en_n,busy}=%b expected %b",
                     nm, which, got, want);
        end
    endtask

    // Monitor: one expected entry per rising edge, sampled 1 time unit later.
    initial begin
        exp_t item;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                item = sb.pop_front();
                check_output(item.name, "dut_a",
                             {grant_a, sel_a, enable_n_a, busy_a}, item.a);
                check_output(item.name, "dut_b",
                             {grant_b, sel_b, enable_n_b, busy_b}, item.b);
            end
        end
    end

    initial begin
        reset = 1'b1;
        req_a = 4'b0000;
        req_b = 4'b0000;

        // Reset values
        apply_stimulus(1, 4'b0000, 4'b0000, off(0), off(0), "reset");
        apply_stimulus(1, 4'b0000, 4'b0000, off(0), off(0), "reset");

        // Single request, one-cycle latency, release, gap then idle
        apply_stimulus(0, 4'b0100, 4'b0000, g(2), off(0), "t1_grant");
        apply_stimulus(0, 4'b0100, 4'b0000, g(2), off(0), "t1_grant");
        apply_stimulus(0, 4'b0000, 4'b0000, off(2), off(0), "t1_gap");
        apply_stimulus(0, 4'b0000, 4'b0000, off(2), off(0), "t1_idle");
        apply_stimulus(1, 4'b0000, 4'b0000, off(0), off(0), "reset2");

        // All four requesting: 8-cycle grants in order 0,1,2,3,0 with gaps
        for (int w = 0; w < 4; w++) begin
            for (int c = 0; c < 8; c++)
                apply_stimulus(0, 4'b1111, 4'b0000, g(w), off(0), "t2_grant");
            apply_stimulus(0, 4'b1111, 4'b0000, off(w), off(0), "t2_gap");
        end
        for (int c = 0; c < 8; c++)
            apply_stimulus(0, 4'b1111, 4'b0000, g(0), off(0), "t2_wrap_grant");
        apply_stimulus(0, 4'b0000, 4'b0000, off(0), off(0), "t2_release");
        apply_stimulus(0, 4'b0000, 4'b0000, off(0), off(0), "t2_idle");

        // Lone requester well past 256 cycles: no gap, and the saturated
        // hold counter still triggers pre-emption once a contender appears
        for (int c = 0; c < 516; c++)
            apply_stimulus(0, 4'b0010, 4'b0000, g(1), off(0), "t3_solo");
        apply_stimulus(0, 4'b0011, 4'b0000, off(1), off(0), "t3_preempt_sat");
        apply_stimulus(0, 4'b0011, 4'b0000, g(0), off(0), "t3_next_owner");
        apply_stimulus(0, 4'b0000, 4'b0000, off(0), off(0), "t3_release");
        apply_stimulus(0, 4'b0000, 4'b0000, off(0), off(0), "t3_idle");

        // Owner 1 releases, re-raises in the gap with 3 pending: 3 wins
        apply_stimulus(0, 4'b0010, 4'b0000, g(1), off(0), "t4_grant1");
        apply_stimulus(0, 4'b1010, 4'b0000, g(1), off(0), "t4_nonowner_rise");
        apply_stimulus(0, 4'b1000, 4'b0000, off(1), off(0), "t4_gap");
        apply_stimulus(0, 4'b1010, 4'b0000, g(3), off(0), "t4_grant3");
        apply_stimulus(0, 4'b1010, 4'b0000, g(3), off(0), "t4_grant3");
        apply_stimulus(0, 4'b0010, 4'b0000, off(3), off(0), "t4_gap2");
        apply_stimulus(0, 4'b0010, 4'b0000, g(1), off(0), "t4_regrant1");
        apply_stimulus(0, 4'b0000, 4'b0000, off(1), off(0), "t4_release");
        apply_stimulus(0, 4'b0000, 4'b0000, off(1), off(0), "t4_idle");

        // Back-to-back same requester through the gap
        apply_stimulus(0, 4'b0010, 4'b0000, g(1), off(0), "b2b_grant");
        apply_stimulus(0, 4'b0000, 4'b0000, off(1), off(0), "b2b_gap");
        apply_stimulus(0, 4'b0010, 4'b0000, g(1), off(0), "b2b_regrant");
        apply_stimulus(0, 4'b0000, 4'b0000, off(1), off(0), "b2b_gap2");
        apply_stimulus(0, 4'b0000, 4'b0000, off(1), off(0), "b2b_idle");

        // MAX_HOLD = 0: requester 0 is never pre-empted
        apply_stimulus(0, 4'b0000, 4'b0011, off(1), g(0), "t5_grant0");
        for (int c = 0; c < 20; c++)
            apply_stimulus(0, 4'b0000, 4'b0011, off(1), g(0), "t5_hold");
        apply_stimulus(0, 4'b0000, 4'b0010, off(1), off(0), "t5_gap");
        apply_stimulus(0, 4'b0000, 4'b0010, off(1), g(1), "t5_grant1");
        apply_stimulus(0, 4'b0000, 4'b0000, off(1), off(1), "t5_release");
        apply_stimulus(0, 4'b0000, 4'b0000, off(1), off(1), "t5_idle");

        // Reset in the 3rd grant cycle, then in a gap
        apply_stimulus(0, 4'b0100, 4'b0000, g(2), off(1), "t6_grant");
        apply_stimulus(0, 4'b0100, 4'b0000, g(2), off(1), "t6_grant");
        apply_stimulus(0, 4'b0100, 4'b0000, g(2), off(1), "t6_grant");
        apply_stimulus(1, 4'b0100, 4'b0000, off(0), off(0), "t6_reset_grant");
        apply_stimulus(0, 4'b1010, 4'b0000, g(1), off(0), "t6_first_after_rst");
        apply_stimulus(0, 4'b1010, 4'b0000, g(1), off(0), "t6_hold");
        apply_stimulus(0, 4'b0000, 4'b0000, off(1), off(0), "t6_gap");
        apply_stimulus(1, 4'b1010, 4'b0000, off(0), off(0), "t6_reset_gap");
        apply_stimulus(0, 4'b1010, 4'b0000, g(1), off(0), "t6_restart");
        apply_stimulus(0, 4'b1000, 4'b0000, off(1), off(0), "t6_gap2");
        apply_stimulus(0, 4'b1000, 4'b0000, g(3), off(0), "t6_grant3");
        apply_stimulus(0, 4'b0000, 4'b0000, off(3), off(0), "t6_release");
        apply_stimulus(0, 4'b0000, 4'b0000, off(3), off(0), "t6_idle");

        repeat (3) @(negedge clock);
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
